lsq_mem_responder: RTL and testbench

Data-memory responder on the far end of the load-store queue issue interface. It accepts issued load and store operations into a small in-order request FIFO and performs them against a word-organised, byte-addressable data RAM with a fixed access latency. It returns one completion per operation (load data or store acknowledge) tagged with PC, ROB number and destination register for the ROB and writeback path. Loads already satisfied by LSQ forwarding bypass the RAM.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/mem_req_fifo.sv | 51 +++++
 rtl/lsq_mem_responder.sv | 145 ++++++++++++++
 tb/tb_lsq_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared request layout, FSM states and operation encodings for the LSQ data-memory responder.
package mem_resp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] address;
        logic [31:0] lwData;
        logic        fromLSQ;
        logic        loadStore;
        logic        storeSize;
        logic [31:0] swData;
        logic [5:0]  ROBNum;
        logic [5:0]  destReg;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_STORE  = 1'b1;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO; full/empty come from the registered count, so a pop never frees a slot
// for a push in the same cycle.
module mem_req_fifo #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(QDEPTH);

    logic [WIDTH-1:0] slots [QDEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/lsq_mem_responder.sv
// LSQ data-memory responder: FIFO-buffered loads/stores against a fixed-latency word RAM.
// Define MEM_LB_SIGN_EXT_EN to sign-extend byte loads (zero-extended otherwise).
module lsq_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2,
    parameter int QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] pcIn,
    input  logic [31:0] addressIn,
    input  logic [31:0] lwDataIn,
    input  logic        fromLSQIn,
    input  logic        loadStoreIn,
    input  logic        storeSizeIn,
    input  logic [31:0] swDataIn,
    input  logic [5:0]  ROBNumIn,
    input  logic [5:0]  destRegIn,
    output logic        compValid,
    output logic [31:0] compPc,
    output logic [5:0]  compROBNum,
    output logic [5:0]  compDestReg,
    output logic [31:0] compData,
    output logic        compIsStore,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    mem_req_t       req_in, head, cur;
    logic           full, empty, push, pop, head_fwd, access_done;
    logic [31:0]    ram [DEPTH_WORDS];
    logic [AW-1:0]  widx;
    logic [1:0]     lane;
    logic [31:0]    ram_word, byte_ext, load_val, comp_data;
    logic [7:0]     ram_byte;
    logic           overflow_q;

    assign req_in = '{pc: pcIn, address: addressIn, lwData: lwDataIn, fromLSQ: fromLSQIn,
                      loadStore: loadStoreIn, storeSize: storeSizeIn, swData: swDataIn,
                      ROBNum: ROBNumIn, destReg: destRegIn};

    assign reqReady = ~full;
    assign push     = reqValid & ~full;

    mem_req_fifo #(.QDEPTH(QDEPTH), .WIDTH($bits(mem_req_t))) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (req_in),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Forwarding only short-circuits loads; a store flagged fromLSQ still goes to the RAM.
    assign head_fwd = head.fromLSQ & (head.loadStore == OP_LOAD);

    // IDLE: wait for a queued request | ACCESS: RAM latency countdown | RESP: one-cycle completion
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        access_done = 1'b0;
        compValid   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = head_fwd ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CW'(1)) begin
                    access_done = 1'b1;
                    state_nx    = RESP;
                end
            end
            RESP: begin
                compValid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    assign widx     = cur.address[AW+1:2];
    assign lane     = cur.address[1:0];
    assign ram_word = ram[widx];
    assign ram_byte = ram_word[{lane, 3'b000} +: 8];

`ifdef MEM_LB_SIGN_EXT_EN
    assign byte_ext = {{24{ram_byte[7]}}, ram_byte};
`else
    assign byte_ext = {24'h0, ram_byte};
`endif

    assign load_val = (cur.storeSize == SIZE_BYTE) ? byte_ext : ram_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            cur        <= '0;
            comp_data  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (reqValid && full) overflow_q <= 1'b1;
            if (pop) begin
                cur       <= head;
                comp_data <= head_fwd ? head.lwData : 32'h0;
                if (!head_fwd) cnt <= CW'(MEM_LATENCY);
            end else if (state == ACCESS) begin
                cnt <= cnt - 1'b1;
                if (access_done && cur.loadStore == OP_LOAD) comp_data <= load_val;
            end
        end
    end

    // The RAM only changes at the access edge, which an asserted reset can never reach.
    always_ff @(posedge clk) begin
        if (access_done && cur.loadStore == OP_STORE) begin
            if (cur.storeSize == SIZE_BYTE) ram[widx][{lane, 3'b000} +: 8] <= cur.swData[7:0];
            else                            ram[widx] <= cur.swData;
        end
    end

    assign compPc      = cur.pc;
    assign compROBNum  = cur.ROBNum;
    assign compDestReg = cur.destReg;
    assign compIsStore = cur.loadStore;
    assign compData    = comp_data;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_lsq_mem_responder.sv
// Directed self-checking bench for lsq_mem_responder (default parameters).
`timescale 1ns/1ps
module tb_lsq_mem_responder;

    typedef struct {
        int          lat;
        logic [31:0] data;
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        st;
    } comp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        reqValid, reqReady;
    logic [31:0] pcIn, addressIn, lwDataIn, swDataIn;
    logic        fromLSQIn, loadStoreIn, storeSizeIn;
    logic [5:0]  ROBNumIn, destRegIn;
    logic        compValid, compIsStore, overflow;
    logic [31:0] compPc, compData;
    logic [5:0]  compROBNum, compDestReg;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [81:0] IDLE_OUTS = {1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'h0, 6'h0, 32'h0};

    always #5 clk = ~clk;

    lsq_mem_responder dut (
        .clk         (clk),
        .rstn        (rstn),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .pcIn        (pcIn),
        .addressIn   (addressIn),
        .lwDataIn    (lwDataIn),
        .fromLSQIn   (fromLSQIn),
        .loadStoreIn (loadStoreIn),
        .storeSizeIn (storeSizeIn),
        .swDataIn    (swDataIn),
        .ROBNumIn    (ROBNumIn),
        .destRegIn   (destRegIn),
        .compValid   (compValid),
        .compPc      (compPc),
        .compROBNum  (compROBNum),
        .compDestReg (compDestReg),
        .compData    (compData),
        .compIsStore (compIsStore),
        .overflow    (overflow)
    );

    task automatic drive(input logic st, input logic sz, input logic fwd, input logic [31:0] addr,
                         input logic [31:0] sw, input logic [31:0] lw, input logic [5:0] rob,
                         input logic [5:0] dest);
        reqValid    = 1'b1;
        loadStoreIn = st;
        storeSizeIn = sz;
        fromLSQIn   = fwd;
        addressIn   = addr;
        swDataIn    = sw;
        lwDataIn    = lw;
        ROBNumIn    = rob;
        destRegIn   = dest;
        pcIn        = 32'h1000 + {26'h0, rob};
    endtask

    task automatic send(input logic st, input logic sz, input logic fwd, input logic [31:0] addr,
                        input logic [31:0] sw, input logic [31:0] lw, input logic [5:0] rob,
                        input logic [5:0] dest, output logic acc);
        @(negedge clk);
        drive(st, sz, fwd, addr, sw, lw, rob, dest);
        acc = reqReady;
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic wait_comp(output comp_t c);
        c = '{lat: -1, data: '0, pc: '0, rob: '0, dest: '0, st: 1'b0};
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (compValid === 1'b1) begin
                c = '{lat: k, data: compData, pc: compPc, rob: compROBNum, dest: compDestReg,
                      st: compIsStore};
                break;
            end
        end
    endtask

    task automatic do_op(input logic st, input logic sz, input logic fwd, input logic [31:0] addr,
                         input logic [31:0] sw, input logic [31:0] lw, input logic [5:0] rob,
                         input logic [5:0] dest, output comp_t c);
        logic acc;
        send(st, sz, fwd, addr, sw, lw, rob, dest, acc);
        wait_comp(c);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        reqValid = 1'b0; pcIn = '0; addressIn = '0; lwDataIn = '0; swDataIn = '0;
        fromLSQIn = 1'b0; loadStoreIn = 1'b0; storeSizeIn = 1'b0; ROBNumIn = '0; destRegIn = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({compValid, reqReady, overflow, compIsStore, compPc, compROBNum, compDestReg, compData} !== IDLE_OUTS)
            $display("FAIL reset_outputs got %h want %h",
                     {compValid, reqReady, overflow, compIsStore, compPc, compROBNum, compDestReg, compData}, IDLE_OUTS);
        else n_pass++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_round_trip();
        comp_t c;
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 6'd1, 6'd2, c);
        n_checks++; if (c.lat !== 3) $display("FAIL sw_latency got %0d want 3", c.lat); else n_pass++;
        n_checks++; if (c.st !== 1'b1 || c.data !== 32'h0) $display("FAIL sw_comp got st=%b data=%h want st=1 data=0", c.st, c.data); else n_pass++;
        n_checks++; if (c.pc !== 32'h1001 || c.rob !== 6'd1 || c.dest !== 6'd2) $display("FAIL sw_tags got pc=%h rob=%0d dest=%0d want 1001/1/2", c.pc, c.rob, c.dest); else n_pass++;
        @(negedge clk);
        n_checks++; if (compValid !== 1'b0) $display("FAIL comp_one_cycle got %b want 0", compValid); else n_pass++;
        do_op(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 6'd2, 6'd7, c);
        n_checks++; if (c.lat !== 3) $display("FAIL lw_latency got %0d want 3", c.lat); else n_pass++;
        n_checks++; if (c.data !== 32'hDEADBEEF || c.st !== 1'b0) $display("FAIL lw_data got %h st=%b want deadbeef st=0", c.data, c.st); else n_pass++;
        n_checks++; if (c.rob !== 6'd2 || c.dest !== 6'd7) $display("FAIL lw_tags got rob=%0d dest=%0d want 2/7", c.rob, c.dest); else n_pass++;
    endtask

    task automatic test_byte_merge();
        comp_t c;
        do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h11223344, 32'h0, 6'd3, 6'd0, c);
        do_op(1'b1, 1'b1, 1'b0, 32'h13, 32'hAB_CD_EF_7F, 32'h0, 6'd4, 6'd0, c);
        n_checks++; if (c.st !== 1'b1 || c.data !== 32'h0 || c.lat !== 3) $display("FAIL sb_comp got st=%b data=%h lat=%0d want 1/0/3", c.st, c.data, c.lat); else n_pass++;
        do_op(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 6'd5, 6'd1, c);
        n_checks++; if (c.data !== 32'h7F223344) $display("FAIL merge_lw got %h want 7f223344", c.data); else n_pass++;
        do_op(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 6'd6, 6'd1, c);
        n_checks++; if (c.data !== 32'h0000007F) $display("FAIL merge_lb3 got %h want 0000007f", c.data); else n_pass++;
        do_op(1'b0, 1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 6'd7, 6'd1, c);
        n_checks++; if (c.data !== 32'h00000033) $display("FAIL merge_lb1 got %h want 00000033", c.data); else n_pass++;
        // 0x412 aliases word 4 (0x10): upper address bits wrap and the low two bits are ignored.
        do_op(1'b0, 1'b0, 1'b0, 32'h412, 32'h0, 32'h0, 6'd8, 6'd1, c);
        n_checks++; if (c.data !== 32'h7F223344) $display("FAIL wrap_misaligned_lw got %h want 7f223344", c.data); else n_pass++;
    endtask

    task automatic test_forward();
        comp_t c;
        do_op(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 32'h55, 6'd5, 6'd9, c);
        n_checks++; if (c.lat !== 1) $display("FAIL fwd_latency got %0d want 1", c.lat); else n_pass++;
        n_checks++; if (c.data !== 32'h55 || c.rob !== 6'd5 || c.st !== 1'b0 || c.dest !== 6'd9) $display("FAIL fwd_comp got data=%h rob=%0d st=%b dest=%0d want 55/5/0/9", c.data, c.rob, c.st, c.dest); else n_pass++;
        do_op(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 6'd9, 6'd1, c);
        n_checks++; if (c.data !== 32'h7F223344) $display("FAIL fwd_ram_untouched got %h want 7f223344", c.data); else n_pass++;
        do_op(1'b1, 1'b0, 1'b1, 32'h14, 32'hCAFEF00D, 32'h99, 6'd10, 6'd1, c);
        n_checks++; if (c.lat !== 3 || c.st !== 1'b1 || c.data !== 32'h0) $display("FAIL fwd_store got lat=%0d st=%b data=%h want 3/1/0", c.lat, c.st, c.data); else n_pass++;
        do_op(1'b0, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 6'd11, 6'd1, c);
        n_checks++; if (c.data !== 32'hCAFEF00D) $display("FAIL fwd_store_written got %h want cafef00d", c.data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        acc0;
        logic [5:0]  acc;
        logic [5:0]  exp_rob  [6] = '{6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25};
        logic [31:0] exp_data [6] = '{32'h0, 32'h111, 32'h0BADF00D, 32'h333, 32'h0000000D, 32'h555};
        logic        exp_st   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int          extra;
        n_checks++; if (overflow !== 1'b0) $display("FAIL overflow_before got %b want 0", overflow); else n_pass++;
        send(1'b1, 1'b0, 1'b0, 32'h40, 32'h0BADF00D, 32'h0, 6'd20, 6'd0, acc0);
        fork
            begin
                @(negedge clk);
                drive(1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h111, 6'd21, 6'd1); acc[0] = reqReady; @(negedge clk);
                drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0,   6'd22, 6'd2); acc[1] = reqReady; @(negedge clk);
                drive(1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h333, 6'd23, 6'd3); acc[2] = reqReady; @(negedge clk);
                drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0,   6'd24, 6'd4); acc[3] = reqReady; @(negedge clk);
                drive(1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h555, 6'd25, 6'd5); acc[4] = reqReady; @(negedge clk);
                drive(1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h666, 6'd26, 6'd6); acc[5] = reqReady; @(negedge clk);
                reqValid = 1'b0;
            end
            begin
                comp_t c;
                for (int i = 0; i < 6; i++) begin
                    wait_comp(c);
                    n_checks++;
                    if (c.lat < 0 || c.rob !== exp_rob[i] || c.data !== exp_data[i] || c.st !== exp_st[i])
                        $display("FAIL b2b_comp%0d got lat=%0d rob=%0d data=%h st=%b want rob=%0d data=%h st=%b",
                                 i, c.lat, c.rob, c.data, c.st, exp_rob[i], exp_data[i], exp_st[i]);
                    else n_pass++;
                    if (c.lat < 0) break;
                end
            end
        join
        n_checks++; if (acc !== 6'b011111) $display("FAIL b2b_ready got %b want 011111", acc); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL overflow_set got %b want 1", overflow); else n_pass++;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (compValid === 1'b1) extra++;
        end
        n_checks++; if (extra !== 0) $display("FAIL dropped_req_completed got %0d want 0", extra); else n_pass++;
        n_checks++; if (overflow !== 1'b1 || reqReady !== 1'b1) $display("FAIL overflow_sticky got ovf=%b rdy=%b want 1/1", overflow, reqReady); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        comp_t c;
        logic  acc;
        int    seen;
        do_op(1'b1, 1'b0, 1'b0, 32'h20, 32'h00001234, 32'h0, 6'd30, 6'd0, c);
        n_checks++; if (c.lat !== 3) $display("FAIL pre_store_latency got %0d want 3", c.lat); else n_pass++;
        send(1'b1, 1'b0, 1'b0, 32'h20, 32'hAAAA0000, 32'h0, 6'd31, 6'd0, acc);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({compValid, reqReady, overflow, compIsStore, compPc, compROBNum, compDestReg, compData} !== IDLE_OUTS)
            $display("FAIL midreset_outputs got %h want %h",
                     {compValid, reqReady, overflow, compIsStore, compPc, compROBNum, compDestReg, compData}, IDLE_OUTS);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (compValid === 1'b1) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL midreset_no_comp got %0d want 0", seen); else n_pass++;
        do_op(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 6'd32, 6'd0, c);
        n_checks++; if (c.data !== 32'h00001234) $display("FAIL midreset_ram got %h want 00001234", c.data); else n_pass++;
    endtask

    task automatic test_sign_ext();
        comp_t       c;
        logic [31:0] exp80, expc3;
`ifdef MEM_LB_SIGN_EXT_EN
        exp80 = 32'hFFFFFF80;
        expc3 = 32'hFFFFFFC3;
`else
        exp80 = 32'h00000080;
        expc3 = 32'h000000C3;
`endif
        do_op(1'b1, 1'b1, 1'b0, 32'h30, 32'h12345680, 32'h0, 6'd40, 6'd0, c);
        do_op(1'b1, 1'b1, 1'b0, 32'h33, 32'h000000C3, 32'h0, 6'd41, 6'd0, c);
        do_op(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 6'd42, 6'd0, c);
        n_checks++; if (c.data !== exp80) $display("FAIL lb_ext_lane0 got %h want %h", c.data, exp80); else n_pass++;
        do_op(1'b0, 1'b1, 1'b0, 32'h33, 32'h0, 32'h0, 6'd43, 6'd0, c);
        n_checks++; if (c.data !== expc3) $display("FAIL lb_ext_lane3 got %h want %h", c.data, expc3); else n_pass++;
        do_op(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 32'h00000080, 6'd44, 6'd0, c);
        n_checks++; if (c.data !== 32'h00000080) $display("FAIL fwd_no_ext got %h want 00000080", c.data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_word_round_trip();
        test_byte_merge();
        test_forward();
        test_back_to_back();
        test_reset_mid_access();
        test_sign_ext();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
